// File: rtl/uart_loader_pkg.sv
// Shared constants, state encodings and baud divisor helper for the UART VRAM loader.
// Optional build macro: UART_LOADER_CSUM_EN (adds a trailing checksum byte to each frame).
package uart_loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef logic [2:0] frame_state_t;
  localparam frame_state_t F_SYNC = 3'd0;
  localparam frame_state_t F_AHI  = 3'd1;
  localparam frame_state_t F_ALO  = 3'd2;
  localparam frame_state_t F_LEN  = 3'd3;
  localparam frame_state_t F_DATA = 3'd4;
  localparam frame_state_t F_CSUM = 3'd5;

  typedef logic [2:0] bit_state_t;
  localparam bit_state_t B_IDLE  = 3'd0;
  localparam bit_state_t B_START = 3'd1;
  localparam bit_state_t B_DATA  = 3'd2;
  localparam bit_state_t B_STOP  = 3'd3;
  localparam bit_state_t B_WAIT  = 3'd4;

  // Clocks per bit, rounded to nearest.
  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: rx synchroniser plus bit FSM, one-clock byte_valid / frame_err pulses.
module uart_rx_byte
  import uart_loader_pkg::*;
#(
  parameter int unsigned DIV = 217
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int unsigned CW = $clog2(DIV + 1);

  logic          rx_meta, rx_sync;
  bit_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    data_d;
  logic          valid_d, ferr_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      state_q    <= B_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      rx_data    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rx_sync    <= rx_meta;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      rx_data    <= data_d;
      byte_valid <= valid_d;
      frame_err  <= ferr_d;
    end
  end

  // Every sample point after the start mid-bit is DIV clocks apart (counter runs DIV-1..0).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    data_d  = rx_data;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      B_IDLE: begin
        if (!rx_sync) begin
          state_d = B_START;
          cnt_d   = CW'(DIV / 2);
        end
      end
      B_START: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (rx_sync) begin
          state_d = B_IDLE;
        end else begin
          state_d = B_DATA;
          cnt_d   = CW'(DIV - 1);
          bit_d   = 3'd0;
        end
      end
      B_DATA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          data_d = {rx_sync, rx_data[7:1]};
          cnt_d  = CW'(DIV - 1);
          bit_d  = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = B_STOP;
        end
      end
      B_STOP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (rx_sync) begin
          valid_d = 1'b1;
          state_d = B_IDLE;
        end else begin
          ferr_d  = 1'b1;
          state_d = B_WAIT;
        end
      end
      B_WAIT: begin
        if (rx_sync) state_d = B_IDLE;
      end
      default: state_d = B_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_vram_loader.sv
// UART frame loader: A5, ADDR_HI, ADDR_LO, LEN, data... written to RAM through a/d/we.
// Optional build macro: UART_LOADER_CSUM_EN (trailing checksum byte, done only on match).
module uart_vram_loader
  import uart_loader_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 25000000,
  parameter int unsigned BAUD    = 115200,
  parameter int unsigned AW      = 15,
  parameter int unsigned TIMEOUT = 250000
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          rx,
  output logic [AW-1:0] a,
  output logic [7:0]    d,
  output logic          we,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int unsigned DIV = calc_div(CLK_HZ, BAUD);
  localparam int unsigned TW  = $clog2(TIMEOUT + 1);

  logic [7:0] rx_data;
  logic       byte_valid, frame_err;

  uart_rx_byte #(.DIV(DIV)) u_rx (
    .clock      (clock),
    .reset_n    (reset_n),
    .rx         (rx),
    .rx_data    (rx_data),
    .byte_valid (byte_valid),
    .frame_err  (frame_err)
  );

  frame_state_t  state_q, state_d;
  logic [AW-1:0] addr_q, addr_d, a_d;
  logic [7:0]    ahi_q, ahi_d, d_d;
  logic [8:0]    cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          we_d, busy_d, done_d, err_d;
`ifdef UART_LOADER_CSUM_EN
  logic [7:0]    csum_q, csum_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) csum_q <= '0;
    else          csum_q <= csum_d;
  end
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= F_SYNC;
      addr_q  <= '0;
      ahi_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      a       <= '0;
      d       <= '0;
      we      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ahi_q   <= ahi_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      a       <= a_d;
      d       <= d_d;
      we      <= we_d;
      busy    <= busy_d;
      done    <= done_d;
      err     <= err_d;
    end
  end

  // Frame FSM; writes land one clock after the byte that carries them.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    ahi_d   = ahi_q;
    cnt_d   = cnt_q;
    tmo_d   = '0;
    a_d     = a;
    d_d     = d;
    we_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = err;
`ifdef UART_LOADER_CSUM_EN
    csum_d  = csum_q;
`endif

    if (state_q != F_SYNC && !byte_valid) begin
      if (tmo_q == TW'(TIMEOUT - 1)) begin
        state_d = F_SYNC;
        err_d   = 1'b1;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end

    if (byte_valid) begin
`ifdef UART_LOADER_CSUM_EN
      csum_d = csum_q + rx_data;
`endif
      case (state_q)
        F_SYNC: begin
          if (rx_data == SYNC_BYTE) begin
            state_d = F_AHI;
            err_d   = 1'b0;
`ifdef UART_LOADER_CSUM_EN
            csum_d  = '0;
`endif
          end
        end
        F_AHI: begin
          ahi_d   = rx_data;
          state_d = F_ALO;
        end
        F_ALO: begin
          addr_d  = AW'({ahi_q, rx_data});
          state_d = F_LEN;
        end
        F_LEN: begin
          cnt_d   = (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
          state_d = F_DATA;
        end
        F_DATA: begin
          we_d   = 1'b1;
          a_d    = addr_q;
          d_d    = rx_data;
          addr_d = addr_q + AW'(1);
          cnt_d  = cnt_q - 9'd1;
          if (cnt_q == 9'd1) begin
`ifdef UART_LOADER_CSUM_EN
            state_d = F_CSUM;
`else
            done_d  = 1'b1;
            state_d = F_SYNC;
`endif
          end
        end
`ifdef UART_LOADER_CSUM_EN
        F_CSUM: begin
          if (8'(csum_q + rx_data) == 8'h00) done_d = 1'b1;
          else                                err_d  = 1'b1;
          state_d = F_SYNC;
        end
`endif
        default: state_d = F_SYNC;
      endcase
    end

    if (frame_err) begin
      state_d = F_SYNC;
      err_d   = 1'b1;
    end

    busy_d = (state_d != F_SYNC);
  end

endmodule

// File: tb/tb_uart_vram_loader.sv
// Self-checking bench for uart_vram_loader: frame vector table plus corner-case sequences.
module tb_uart_vram_loader;

  localparam int unsigned BIT_CLKS = 10;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        rx;
  logic [14:0] a;
  logic [7:0]  d;
  logic        we, busy, done, err;

  always #5 clock = ~clock;

  uart_vram_loader #(
    .CLK_HZ (1000000),
    .BAUD   (100000),
    .AW     (15),
    .TIMEOUT(300)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .rx     (rx),
    .a      (a),
    .d      (d),
    .we     (we),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  typedef struct packed {
    logic [14:0] a;
    logic [7:0]  d;
    logic        done;
  } wr_t;

  typedef struct packed {
    logic [7:0]  ahi;
    logic [7:0]  alo;
    logic [7:0]  len;
    logic [31:0] dat;
    logic [14:0] last_a;
    logic [7:0]  last_d;
  } fvec_t;

  wr_t         sb[$];
  wr_t         mon_e;
  logic [7:0]  dbuf [256];
  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  int unsigned done_cnt = 0;
  int unsigned we_cnt = 0;
  logic        prev_we = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // Write monitor: each we pulse pops one scoreboard entry.
  always @(negedge clock) begin
    if (reset_n) begin
      if (done) done_cnt++;
      if (we) begin
        we_cnt++;
        check("we_gap", 32'(prev_we), 32'd0);
        if (sb.size() == 0) begin
          check("unexpected_we", 32'(sb.size()), 32'd1);
        end else begin
          mon_e = sb.pop_front();
          check("we_addr", 32'(a), 32'(mon_e.a));
          check("we_data", 32'(d), 32'(mon_e.d));
`ifndef UART_LOADER_CSUM_EN
          check("we_done", 32'(done), 32'(mon_e.done));
`endif
        end
      end
`ifndef UART_LOADER_CSUM_EN
      if (done) check("done_with_we", 32'(we), 32'd1);
`endif
      prev_we = we;
    end else begin
      prev_we = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT_CLKS) @(negedge clock);
    end
    rx = stop;
    repeat (BIT_CLKS) @(negedge clock);
    rx = 1'b1;
  endtask

  // Sends a full frame from dbuf[0..n-1], pushing each expected write first.
  task automatic send_frame(input logic [7:0] ahi, input logic [7:0] alo, input logic [7:0] len,
                            input int n, input logic bad_csum);
    logic [14:0] addr;
    logic [7:0]  sum;
    addr = 15'({ahi, alo});
    sum  = 8'(ahi + alo + len);
    done_cnt = 0;
    send_byte(8'hA5, 1'b1);
    send_byte(ahi, 1'b1);
    send_byte(alo, 1'b1);
    send_byte(len, 1'b1);
    for (int i = 0; i < n; i++) begin
      sb.push_back('{a: addr, d: dbuf[i], done: (i == n - 1)});
      sum  = sum + dbuf[i];
      addr = addr + 15'd1;
      send_byte(dbuf[i], 1'b1);
    end
`ifdef UART_LOADER_CSUM_EN
    send_byte(bad_csum ? 8'(8'h01 - sum) : 8'(8'h00 - sum), 1'b1);
`else
    if (bad_csum) $display("note: checksum disabled in this build");
`endif
    repeat (10) @(negedge clock);
  endtask

  task automatic end_frame(input string nm, input int exp_done, input logic exp_err);
    check({nm, "_sb_empty"}, 32'(sb.size()), 32'd0);
    check({nm, "_done_cnt"}, 32'(done_cnt), 32'(exp_done));
    check({nm, "_err"}, 32'(err), 32'(exp_err));
    check({nm, "_busy"}, 32'(busy), 32'd0);
  endtask

  fvec_t vecs [4];
  int unsigned we_base;

  initial begin
    vecs[0] = '{ahi: 8'h12, alo: 8'h34, len: 8'h03, dat: 32'h11223300, last_a: 15'h1236, last_d: 8'h33};
    vecs[1] = '{ahi: 8'h7F, alo: 8'hFF, len: 8'h02, dat: 32'hAABB0000, last_a: 15'h0000, last_d: 8'hBB};
    vecs[2] = '{ahi: 8'h40, alo: 8'h00, len: 8'h04, dat: 32'hDEADBEEF, last_a: 15'h4003, last_d: 8'hEF};
    vecs[3] = '{ahi: 8'h00, alo: 8'h00, len: 8'h01, dat: 32'h5A000000, last_a: 15'h0000, last_d: 8'h5A};

    reset_n = 1'b0;
    rx      = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_a", 32'(a), 32'd0);
    check("rst_d", 32'(d), 32'd0);
    check("rst_we", 32'(we), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);

    // Table-driven frames
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < 4; i++) dbuf[i] = vecs[v].dat[31 - 8*i -: 8];
      send_frame(vecs[v].ahi, vecs[v].alo, vecs[v].len, int'(vecs[v].len), 1'b0);
      end_frame($sformatf("vec%0d", v), 1, 1'b0);
      check($sformatf("vec%0d_last_a", v), 32'(a), 32'(vecs[v].last_a));
      check($sformatf("vec%0d_last_d", v), 32'(d), 32'(vecs[v].last_d));
    end

    // Noise bytes before sync are ignored
    send_byte(8'h00, 1'b1);
    send_byte(8'h5A, 1'b1);
    repeat (5) @(negedge clock);
    check("noise_busy", 32'(busy), 32'd0);
    check("noise_err", 32'(err), 32'd0);
    dbuf[0] = 8'h77;
    send_frame(8'h01, 8'h00, 8'h01, 1, 1'b0);
    end_frame("noise", 1, 1'b0);
    check("noise_a", 32'(a), 32'h0100);

    // Framing error inside a frame
    we_base = we_cnt;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h10, 1'b1);
    send_byte(8'h02, 1'b1);
    check("ferr_busy_mid", 32'(busy), 32'd1);
    send_byte(8'h3C, 1'b0);
    repeat (10) @(negedge clock);
    check("ferr_err", 32'(err), 32'd1);
    check("ferr_busy", 32'(busy), 32'd0);
    check("ferr_no_write", 32'(we_cnt - we_base), 32'd0);
    dbuf[0] = 8'h55;
    send_frame(8'h00, 8'h10, 8'h01, 1, 1'b0);
    end_frame("ferr_recover", 1, 1'b0);

    // Inter-byte timeout
    done_cnt = 0;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h10, 1'b1);
    send_byte(8'h04, 1'b1);
    sb.push_back('{a: 15'h0010, d: 8'hEE, done: 1'b0});
    send_byte(8'hEE, 1'b1);
    repeat (250) @(negedge clock);
    check("tmo_busy_before", 32'(busy), 32'd1);
    check("tmo_err_before", 32'(err), 32'd0);
    repeat (150) @(negedge clock);
    end_frame("tmo", 0, 1'b1);

    // LEN=0 means 256 bytes, addresses 0..255
    for (int i = 0; i < 256; i++) dbuf[i] = 8'(i);
    we_base = we_cnt;
    send_frame(8'h00, 8'h00, 8'h00, 256, 1'b0);
    end_frame("len256", 1, 1'b0);
    check("len256_writes", 32'(we_cnt - we_base), 32'd256);

    // Reset in the middle of the data phase
    send_byte(8'hA5, 1'b1);
    send_byte(8'h20, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h04, 1'b1);
    sb.push_back('{a: 15'h2000, d: 8'h01, done: 1'b0});
    send_byte(8'h01, 1'b1);
    sb.push_back('{a: 15'h2001, d: 8'h02, done: 1'b0});
    send_byte(8'h02, 1'b1);
    rx = 1'b0;
    repeat (40) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("mrst_a", 32'(a), 32'd0);
    check("mrst_d", 32'(d), 32'd0);
    check("mrst_we", 32'(we), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_sb", 32'(sb.size()), 32'd0);
    @(negedge clock);
    rx = 1'b1;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (20) @(negedge clock);
    dbuf[0] = 8'h99;
    send_frame(8'h20, 8'h00, 8'h01, 1, 1'b0);
    end_frame("mrst_after", 1, 1'b0);
    check("mrst_after_a", 32'(a), 32'h2000);

`ifdef UART_LOADER_CSUM_EN
    dbuf[0] = 8'h10;
    send_frame(8'h12, 8'h34, 8'h01, 1, 1'b1);
    end_frame("csum_bad", 0, 1'b1);
    check("csum_bad_a", 32'(a), 32'h1234);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
